// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES control slice.
// Holds the arbiter state encoding and the default block length so that
// the arbiter, the byte selector and later arbiters agree on them.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY1 = 2'd1,
        ST_BUSY2 = 2'd2
    } arbState_t;

    localparam int DEFAULT_BLOCK_BYTES = 16;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   Req1, Req2  - pending requests
//   LastGrant2  - 1 when source 2 was served last, 0 when source 1 was
//   Pick1/Pick2 - one-hot (or zero) choice of the source to serve next
// On a tie the source that was not served last wins.
module rr_pick2 (
    input  logic Req1,
    input  logic Req2,
    input  logic LastGrant2,
    output logic Pick1,
    output logic Pick2
);

    assign Pick1 = Req1 & (~Req2 | LastGrant2);
    assign Pick2 = Req2 & (~Req1 | ~LastGrant2);

endmodule

// File: rtl/byte_source_arbiter.sv
// Arbitrates the shared 2:1 byte path into the AES core between two byte
// sources. A granted source owns the path for BLOCK_BYTES strobes, then the
// path returns to IDLE for at least one cycle and round-robin picks again.
//
// Ports:
//   Clk, Reset               - clock, asynchronous active-high reset
//   Req1, Req2               - level block requests, held until granted
//   ByteStrobe1, ByteStrobe2 - byte-ready strobes, one byte per high cycle
//   Grant1, Grant2           - path owner
//   Select                   - byte-mux select (0 = source 1, 1 = source 2)
//   Busy                     - a block is in progress
//   ByteCount                - bytes accepted in the current block
//   BlockDone                - one-cycle pulse after the last byte
//   Timeout                  - one-cycle pulse on a stalled-block abort
//
// Build option: define ARB_TIMEOUT_EN to abort a block after TIMEOUT_CYCLES
// cycles without a counted strobe. Without it Timeout is tied low and a
// block waits indefinitely.
//
// state    | meaning
// ST_IDLE  | no owner, arbitrate pending requests
// ST_BUSY1 | source 1 owns the path, counting ByteStrobe1
// ST_BUSY2 | source 2 owns the path, counting ByteStrobe2
module byte_source_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int BLOCK_BYTES    = DEFAULT_BLOCK_BYTES,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req1,
    input  logic             Req2,
    input  logic             ByteStrobe1,
    input  logic             ByteStrobe2,
    output logic             Grant1,
    output logic             Grant2,
    output logic             Select,
    output logic             Busy,
    output logic [CNT_W-1:0] ByteCount,
    output logic             BlockDone,
    output logic             Timeout
);

    arbState_t state;
    logic      lastGrant2;
    logic      pick1;
    logic      pick2;
    logic      strobeSel;
    logic      lastByte;

    rr_pick2 uPick (
        .Req1       (Req1),
        .Req2       (Req2),
        .LastGrant2 (lastGrant2),
        .Pick1      (pick1),
        .Pick2      (pick2)
    );

    // Only the owner's strobe is ever looked at; the other one is ignored.
    assign strobeSel = (state == ST_BUSY2) ? ByteStrobe2 : ByteStrobe1;
    assign lastByte  = (ByteCount == CNT_W'(BLOCK_BYTES - 1));

`ifdef ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter of strobe-less cycles still allowed; the abort fires on
    // the stalled cycle that finds it already at zero.
    logic [IDLE_W-1:0] idleLeft;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign Timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            lastGrant2 <= 1'b1;
            Grant1     <= 1'b0;
            Grant2     <= 1'b0;
            Select     <= 1'b0;
            Busy       <= 1'b0;
            ByteCount  <= '0;
            BlockDone  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            Timeout    <= 1'b0;
            idleLeft   <= '0;
`endif
        end else begin
            BlockDone <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            Timeout   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // Select only moves here, so the mux never switches mid-block.
                    if (pick1 || pick2) begin
                        state     <= pick2 ? ST_BUSY2 : ST_BUSY1;
                        Grant1    <= pick1;
                        Grant2    <= pick2;
                        Select    <= pick2;
                        Busy      <= 1'b1;
                        ByteCount <= '0;
`ifdef ARB_TIMEOUT_EN
                        idleLeft  <= IDLE_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                ST_BUSY1, ST_BUSY2: begin
                    if (strobeSel) begin
`ifdef ARB_TIMEOUT_EN
                        idleLeft <= IDLE_W'(TIMEOUT_CYCLES - 1);
`endif
                        if (lastByte) begin
                            state      <= ST_IDLE;
                            Grant1     <= 1'b0;
                            Grant2     <= 1'b0;
                            Busy       <= 1'b0;
                            ByteCount  <= '0;
                            BlockDone  <= 1'b1;
                            lastGrant2 <= (state == ST_BUSY2);
                        end else begin
                            ByteCount <= ByteCount + CNT_W'(1);
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (idleLeft == '0) begin
                        state      <= ST_IDLE;
                        Grant1     <= 1'b0;
                        Grant2     <= 1'b0;
                        Busy       <= 1'b0;
                        ByteCount  <= '0;
                        Timeout    <= 1'b1;
                        lastGrant2 <= (state == ST_BUSY2);
                    end else begin
                        idleLeft <= idleLeft - IDLE_W'(1);
                    end
`endif
                end
                default: begin
                    state  <= ST_IDLE;
                    Grant1 <= 1'b0;
                    Grant2 <= 1'b0;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_source_arbiter.sv
// Bench for byte_source_arbiter: directed scenarios with literal expectations,
// then randomized requests/strobes checked every cycle against a
// transaction-level model of block ownership.
module tb_byte_source_arbiter;

    localparam int BLOCK = 16;
    localparam int TO    = 10;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req1 = 1'b0, Req2 = 1'b0;
    logic       ByteStrobe1 = 1'b0, ByteStrobe2 = 1'b0;
    logic       Grant1, Grant2, Select, Busy, BlockDone, Timeout;
    logic [7:0] ByteCount;

    int checks = 0;
    int errors = 0;
    bit cmpOn  = 1'b0;

    byte_source_arbiter #(
        .BLOCK_BYTES    (BLOCK),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req1        (Req1),
        .Req2        (Req2),
        .ByteStrobe1 (ByteStrobe1),
        .ByteStrobe2 (ByteStrobe2),
        .Grant1      (Grant1),
        .Grant2      (Grant2),
        .Select      (Select),
        .Busy        (Busy),
        .ByteCount   (ByteCount),
        .BlockDone   (BlockDone),
        .Timeout     (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the path, how many bytes of the
    // block it has delivered, and who was served last.
    int owner   = 0;
    int lastSrc = 2;
    int taken   = 0;
    int stall   = 0;
    int expSel  = 0;
    int expDone = 0;
    int expTo   = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner = 0; lastSrc = 2; taken = 0; stall = 0;
            expSel = 0; expDone = 0; expTo = 0;
        end else begin
            expDone = 0;
            expTo   = 0;
            if (owner == 0) begin
                if (Req1 && Req2) owner = (lastSrc == 1) ? 2 : 1;
                else if (Req1)    owner = 1;
                else if (Req2)    owner = 2;
                if (owner != 0) begin
                    expSel = owner - 1;
                    taken  = 0;
                    stall  = 0;
                end
            end else begin
                if ((owner == 1) ? ByteStrobe1 : ByteStrobe2) begin
                    taken++;
                    stall = 0;
                    if (taken == BLOCK) begin
                        expDone = 1; lastSrc = owner; owner = 0; taken = 0;
                    end
                end else begin
                    stall++;
`ifdef ARB_TIMEOUT_EN
                    if (stall == TO) begin
                        expTo = 1; lastSrc = owner; owner = 0; taken = 0;
                    end
`endif
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (cmpOn) begin
            chk("grant1",    int'(Grant1),    int'(owner == 1));
            chk("grant2",    int'(Grant2),    int'(owner == 2));
            chk("busy",      int'(Busy),      int'(owner != 0));
            chk("select",    int'(Select),    expSel);
            chk("byteCount", int'(ByteCount), taken);
            chk("blockDone", int'(BlockDone), expDone);
            chk("timeout",   int'(Timeout),   expTo);
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulseReset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        stepN(3);
        cmpOn = 1'b1;
        chk("rst_grant1", int'(Grant1), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_select", int'(Select), 0);
        chk("rst_count", int'(ByteCount), 0);
        Reset = 1'b0;
        step();

        // Single source, back-to-back strobes.
        Req1 = 1'b1;
        step();
        chk("single_grant1", int'(Grant1), 1);
        chk("single_select", int'(Select), 0);
        Req1 = 1'b0;
        ByteStrobe1 = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            chk("single_count", int'(ByteCount), i);
            step();
        end
        chk("single_done", int'(BlockDone), 1);
        chk("single_grant_off", int'(Grant1), 0);
        chk("single_count_clr", int'(ByteCount), 0);
        ByteStrobe1 = 1'b0;
        step();
        chk("single_done_pulse", int'(BlockDone), 0);

        // Tie held through two blocks after reset.
        pulseReset();
        Req1 = 1'b1; Req2 = 1'b1;
        step();
        chk("tie_first_grant1", int'(Grant1), 1);
        chk("tie_first_select", int'(Select), 0);
        ByteStrobe1 = 1'b1;
        stepN(BLOCK);
        chk("tie_gap_idle", int'(Busy), 0);
        chk("tie_gap_done", int'(BlockDone), 1);
        ByteStrobe1 = 1'b0; ByteStrobe2 = 1'b1;
        step();
        chk("tie_second_grant2", int'(Grant2), 1);
        chk("tie_second_select", int'(Select), 1);
        Req1 = 1'b0; Req2 = 1'b0;
        stepN(BLOCK);
        chk("tie_second_done", int'(BlockDone), 1);
        chk("tie_select_hold", int'(Select), 1);
        ByteStrobe2 = 1'b0;
        step();

        // Strobe isolation: foreign strobes are ignored.
        Req1 = 1'b1;
        step();
        Req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ByteStrobe2 = (i < 5);
            ByteStrobe1 = (i >= 5);
            step();
        end
        ByteStrobe1 = 1'b0; ByteStrobe2 = 1'b0;
        chk("iso_count", int'(ByteCount), 3);
        chk("iso_select", int'(Select), 0);
        chk("iso_grant1", int'(Grant1), 1);

        // Reset mid-block at ByteCount 7.
        ByteStrobe1 = 1'b1;
        stepN(4);
        ByteStrobe1 = 1'b0;
        chk("pre_reset_count", int'(ByteCount), 7);
        Reset = 1'b1;
        #1;
        chk("async_rst_grant1", int'(Grant1), 0);
        chk("async_rst_busy", int'(Busy), 0);
        chk("async_rst_count", int'(ByteCount), 0);
        chk("async_rst_done", int'(BlockDone), 0);
        step();
        Reset = 1'b0;
        Req1 = 1'b1;
        step();
        chk("rereq_grant1", int'(Grant1), 1);
        Req1 = 1'b0;
        ByteStrobe1 = 1'b1;
        stepN(BLOCK);
        chk("rereq_done", int'(BlockDone), 1);
        ByteStrobe1 = 1'b0;
        step();

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            pulseReset();
            Req2 = 1'b1;
            step();
            chk("to_grant2", int'(Grant2), 1);
            Req2 = 1'b0;
            ByteStrobe2 = 1'b1;
            stepN(4);
            ByteStrobe2 = 1'b0;
            chk("to_count", int'(ByteCount), 4);
            n = 0;
            for (int i = 1; i <= 20 && n == 0; i++) begin
                step();
                if (Timeout) n = i;
            end
            chk("to_latency", n, 10);
            chk("to_no_done", int'(BlockDone), 0);
            chk("to_released", int'(Grant2), 0);
            Req1 = 1'b1; Req2 = 1'b1;
            step();
            chk("to_next_grant1", int'(Grant1), 1);
            Req1 = 1'b0; Req2 = 1'b0;
            ByteStrobe1 = 1'b1;
            stepN(BLOCK);
            ByteStrobe1 = 1'b0;
            step();
        end
`endif

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                Reset = 1'b1;
                #2;
                Reset = 1'b0;
            end
            if (!Req1) Req1 = ($urandom_range(0, 7) == 0);
            else if (Grant1 && $urandom_range(0, 1) == 1) Req1 = 1'b0;
            if (!Req2) Req2 = ($urandom_range(0, 7) == 0);
            else if (Grant2 && $urandom_range(0, 1) == 1) Req2 = 1'b0;
            ByteStrobe1 = ($urandom_range(0, 3) != 0);
            ByteStrobe2 = ($urandom_range(0, 3) != 0);
            step();
        end

        cmpOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
